// File: rtl/mult_share_arbiter.sv
// Arbiter that time-shares one unsigned 4x4 multiplier among NREQ requesters (round-robin).
// Define MULT_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no last_winner register).

module multiplierFourToFour (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);
   assign p = {4'b0000, a} * {4'b0000, b};
endmodule

module mult_share_arbiter #(
   parameter  int NREQ = 4,
   localparam int ID_W = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_i,
   input  logic [4*NREQ-1:0] a_i,
   input  logic [4*NREQ-1:0] b_i,
   output logic [NREQ-1:0]   ack_o,
   output logic              done_o,
   output logic [7:0]        result_o,
   output logic [ID_W-1:0]   result_id_o,
   output logic              busy_o,
   output logic [1:0]        state_o
);

   // Handshake: requester i holds req_i[i] and its operands until the one-cycle
   // ack_o[i]; done_o is a one-cycle pulse qualifying result_o/result_id_o.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      op_a_q, op_b_q;
   logic [3:0]      sel_a, sel_b;
   logic [ID_W-1:0] id_q;
   logic [ID_W-1:0] win;
   logic [NREQ-1:0] grant;
   logic            found;
   logic [7:0]      product;

`ifdef MULT_ARB_FIXED_PRIO_EN
   always_comb begin
      win   = '0;
      grant = '0;
      sel_a = '0;
      sel_b = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_i[i] && !found) begin
            found    = 1'b1;
            win      = ID_W'(i);
            grant[i] = 1'b1;
            sel_a    = a_i[4*i +: 4];
            sel_b    = b_i[4*i +: 4];
         end
      end
   end
`else
   logic [ID_W-1:0] last_q;

   // First pass looks above the last winner, second pass wraps around to index 0.
   always_comb begin
      win   = '0;
      grant = '0;
      sel_a = '0;
      sel_b = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_i[i] && !found && (i > int'(last_q))) begin
            found    = 1'b1;
            win      = ID_W'(i);
            grant[i] = 1'b1;
            sel_a    = a_i[4*i +: 4];
            sel_b    = b_i[4*i +: 4];
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (req_i[i] && !found) begin
            found    = 1'b1;
            win      = ID_W'(i);
            grant[i] = 1'b1;
            sel_a    = a_i[4*i +: 4];
            sel_b    = b_i[4*i +: 4];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= ID_W'(NREQ - 1);
      end else if (state_q == IDLE && found) begin
         last_q <= win;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (found) state_d = MUL;
         MUL:     state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o  = (state_q != IDLE);
      state_o = state_q;
   end

   // The multiplier only ever sees the captured operands.
   multiplierFourToFour u_mult (
      .a (op_a_q),
      .b (op_b_q),
      .p (product)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_q      <= '0;
         op_b_q      <= '0;
         id_q        <= '0;
         ack_o       <= '0;
         done_o      <= 1'b0;
         result_o    <= 8'h00;
         result_id_o <= '0;
      end else begin
         ack_o  <= '0;
         done_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (found) begin
                  op_a_q <= sel_a;
                  op_b_q <= sel_b;
                  id_q   <= win;
                  ack_o  <= grant;
               end
            end
            MUL: begin
               result_o    <= product;
               result_id_o <= id_q;
               done_o      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter (NREQ = 4).

module tb_mult_share_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_i;
   logic [15:0] a_i;
   logic [15:0] b_i;
   logic [3:0]  ack_o;
   logic        done_o;
   logic [7:0]  result_o;
   logic [1:0]  result_id_o;
   logic        busy_o;
   logic [1:0]  state_o;

   int checks;
   int failures;

   mult_share_arbiter #(.NREQ(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_i),
      .a_i         (a_i),
      .b_i         (b_i),
      .ack_o       (ack_o),
      .done_o      (done_o),
      .result_o    (result_o),
      .result_id_o (result_id_o),
      .busy_o      (busy_o),
      .state_o     (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      req_i = '0;
      a_i   = '0;
      b_i   = '0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_i = '0;
      a_i   = '0;
      b_i   = '0;
      #2;
      checks++; if (ack_o !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack_o); end
      checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      checks++; if (result_o !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result_o); end
      checks++; if (result_id_o !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", result_id_o); end
      checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      req_i = 4'b0001;
      a_i   = 16'h0009;
      b_i   = 16'h0004;
      tick();
      checks++; if (ack_o !== 4'b0001) begin failures++; $display("FAIL single_ack got=%b exp=0001", ack_o); end
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy_o); end
      checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL single_early_done got=%b exp=0", done_o); end
      req_i = 4'b0000;
      tick();
      checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1", done_o); end
      checks++; if (result_o !== 8'h24) begin failures++; $display("FAIL single_result got=%h exp=24", result_o); end
      checks++; if (result_id_o !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", result_id_o); end
      checks++; if (ack_o !== 4'b0000) begin failures++; $display("FAIL single_ack_clear got=%b exp=0000", ack_o); end
      tick();
      checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL single_done_clear got=%b exp=0", done_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", busy_o); end
      checks++; if (result_o !== 8'h24) begin failures++; $display("FAIL single_hold got=%h exp=24", result_o); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_id [4];
      logic [7:0] exp_r  [4];
      logic [3:0] exp_ack;
      exp_id[0] = 2'd0; exp_r[0] = 8'h0F;
      exp_id[1] = 2'd1; exp_r[1] = 8'hE1;
      exp_id[2] = 2'd3; exp_r[2] = 8'h0E;
      exp_id[3] = 2'd0; exp_r[3] = 8'h0F;
      apply_reset();
      req_i = 4'b1011;
      a_i   = 16'h20F3;
      b_i   = 16'h70F5;
      for (int k = 0; k < 4; k++) begin
         exp_ack = 4'b0001 << exp_id[k];
         tick();
         checks++; if (ack_o !== exp_ack) begin failures++; $display("FAIL rr_ack[%0d] got=%b exp=%b", k, ack_o, exp_ack); end
         checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rr_gap_done[%0d] got=%b exp=0", k, done_o); end
         tick();
         checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL rr_done[%0d] got=%b exp=1", k, done_o); end
         checks++; if (result_o !== exp_r[k]) begin failures++; $display("FAIL rr_result[%0d] got=%h exp=%h", k, result_o, exp_r[k]); end
         checks++; if (result_id_o !== exp_id[k]) begin failures++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", k, result_id_o, exp_id[k]); end
         tick();
         checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rr_resp_done[%0d] got=%b exp=0", k, done_o); end
         checks++; if (ack_o !== 4'b0000) begin failures++; $display("FAIL rr_resp_ack[%0d] got=%b exp=0000", k, ack_o); end
      end
      req_i = 4'b0000;
      tick();
      tick();
      tick();
   endtask

   task automatic test_withdrawal();
      req_i = 4'b0001;
      a_i   = 16'h0003;
      b_i   = 16'h0003;
      tick();
      checks++; if (ack_o !== 4'b0001) begin failures++; $display("FAIL wd_ack got=%b exp=0001", ack_o); end
      req_i = 4'b0100;
      a_i   = 16'h0503;
      b_i   = 16'h0503;
      tick();
      checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL wd_done got=%b exp=1", done_o); end
      checks++; if (result_id_o !== 2'd0) begin failures++; $display("FAIL wd_id got=%0d exp=0", result_id_o); end
      checks++; if (result_o !== 8'h09) begin failures++; $display("FAIL wd_result got=%h exp=09", result_o); end
      req_i = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++; if (ack_o !== 4'b0000) begin failures++; $display("FAIL wd_no_ack[%0d] got=%b exp=0000", k, ack_o); end
         checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL wd_no_done[%0d] got=%b exp=0", k, done_o); end
      end
   endtask

   task automatic test_reset_mid();
      req_i = 4'b0001;
      a_i   = 16'h0007;
      b_i   = 16'h0008;
      tick();
      checks++; if (ack_o !== 4'b0001) begin failures++; $display("FAIL rm_ack got=%b exp=0001", ack_o); end
      req_i = 4'b0000;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (ack_o !== 4'b0000) begin failures++; $display("FAIL rm_ack_clr got=%b exp=0000", ack_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy_o); end
      checks++; if (result_o !== 8'h00) begin failures++; $display("FAIL rm_result got=%h exp=00", result_o); end
      checks++; if (result_id_o !== 2'd0) begin failures++; $display("FAIL rm_id got=%0d exp=0", result_id_o); end
      tick();
      checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rm_no_done got=%b exp=0", done_o); end
      req_i = 4'b0011;
      a_i   = 16'h0064;
      b_i   = 16'h0032;
      rst_n = 1'b1;
      tick();
      checks++; if (ack_o !== 4'b0001) begin failures++; $display("FAIL rm_first_grant got=%b exp=0001", ack_o); end
      req_i = 4'b0000;
      tick();
      checks++; if (result_o !== 8'h08) begin failures++; $display("FAIL rm_result_after got=%h exp=08", result_o); end
      checks++; if (result_id_o !== 2'd0) begin failures++; $display("FAIL rm_id_after got=%0d exp=0", result_id_o); end
      tick();
   endtask

   task automatic test_boundary();
      req_i = 4'b0100;
      a_i   = 16'h0000;
      b_i   = 16'h0F00;
      tick();
      checks++; if (ack_o !== 4'b0100) begin failures++; $display("FAIL bd_ack2 got=%b exp=0100", ack_o); end
      req_i = 4'b0000;
      tick();
      checks++; if (result_o !== 8'h00) begin failures++; $display("FAIL bd_zero got=%h exp=00", result_o); end
      checks++; if (result_id_o !== 2'd2) begin failures++; $display("FAIL bd_id2 got=%0d exp=2", result_id_o); end
      tick();
      req_i = 4'b1000;
      a_i   = 16'hF000;
      b_i   = 16'hF000;
      tick();
      checks++; if (ack_o !== 4'b1000) begin failures++; $display("FAIL bd_ack3 got=%b exp=1000", ack_o); end
      req_i = 4'b0000;
      a_i   = 16'h1111;
      b_i   = 16'h2222;
      tick();
      checks++; if (result_o !== 8'hE1) begin failures++; $display("FAIL bd_max got=%h exp=e1", result_o); end
      checks++; if (result_id_o !== 2'd3) begin failures++; $display("FAIL bd_id3 got=%0d exp=3", result_id_o); end
      tick();
   endtask

   task automatic test_priority();
      logic [1:0] exp_id [3];
      logic [7:0] exp_r  [3];
      logic [3:0] exp_ack;
`ifdef MULT_ARB_FIXED_PRIO_EN
      exp_id[0] = 2'd0; exp_r[0] = 8'h0F;
      exp_id[1] = 2'd0; exp_r[1] = 8'h0F;
      exp_id[2] = 2'd0; exp_r[2] = 8'h0F;
`else
      exp_id[0] = 2'd0; exp_r[0] = 8'h0F;
      exp_id[1] = 2'd1; exp_r[1] = 8'h08;
      exp_id[2] = 2'd0; exp_r[2] = 8'h0F;
`endif
      apply_reset();
      req_i = 4'b0011;
      a_i   = 16'h0023;
      b_i   = 16'h0045;
      for (int k = 0; k < 3; k++) begin
         exp_ack = 4'b0001 << exp_id[k];
         tick();
         checks++; if (ack_o !== exp_ack) begin failures++; $display("FAIL prio_ack[%0d] got=%b exp=%b", k, ack_o, exp_ack); end
         tick();
         checks++; if (result_o !== exp_r[k]) begin failures++; $display("FAIL prio_result[%0d] got=%h exp=%h", k, result_o, exp_r[k]); end
         checks++; if (result_id_o !== exp_id[k]) begin failures++; $display("FAIL prio_id[%0d] got=%0d exp=%0d", k, result_id_o, exp_id[k]); end
         tick();
      end
      req_i = 4'b0000;
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_withdrawal();
      test_reset_mid();
      test_boundary();
      test_priority();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
